cycle_check_monitor: RTL and testbench

- Parametrised, synthesizable checker for processor cycle accuracy.
- Sits beside `proc` and watches its opcode-fetch strobe and PC.
- Compares each instruction's address and cycle count against a programmable table of expected values.
- Reports mismatches through a buffered valid/ready error stream and ends each run with a pass/fail verdict. Usable on FPGA as well as in simulation.

---
 rtl/cycle_check_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_cycle_check_monitor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_check_monitor.sv
// cycle_check_monitor: watches a core's opcode-fetch strobe and PC and
// compares each instruction's address and cycle count against a
// programmable table. Mismatches are queued in a first-word fall-through
// error FIFO, and each run ends with a pass/fail verdict.
module cycle_check_monitor #(
   parameter int                ADDR_W        = 16,
   parameter int                DEPTH         = 16,
   parameter int                CNT_W         = 8,
   parameter int                ERR_DEPTH     = 4,
   parameter logic [ADDR_W-1:0] START_ADDR    = 16'h8000,
   parameter int                START_TIMEOUT = 64,
   parameter int                WDOG          = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     n_entries,
   input  logic                       fetch,
   input  logic [ADDR_W-1:0]          pc,
   input  logic                       exp_wr_en,
   input  logic [$clog2(DEPTH)-1:0]   exp_wr_idx,
   input  logic [ADDR_W-1:0]          exp_wr_pc,
   input  logic [CNT_W-1:0]           exp_wr_cyc,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       start_fail,
   output logic [7:0]                 error_count,
   output logic                       err_overflow,
   output logic                       err_valid,
   input  logic                       err_ready,
   output logic [2:0]                 err_kind,
   output logic [$clog2(DEPTH)-1:0]   err_idx,
   output logic [ADDR_W-1:0]          err_pc,
   output logic [CNT_W-1:0]           err_meas,
   output logic [CNT_W-1:0]           err_exp
);

   localparam int IW = $clog2(DEPTH);
   localparam int FW = $clog2(ERR_DEPTH);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam int RW = 3 + IW + ADDR_W + 2 * CNT_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_RUN,
      S_DONE,
      S_FAIL_START
   } state_t;

   state_t            state_reg, state_next;

   logic [CNT_W-1:0]  cnt_reg;
   logic [IW-1:0]     idx_reg;
   logic [TW-1:0]     wait_cnt_reg;
   logic [ADDR_W-1:0] last_pc_reg;
   logic [7:0]        error_count_reg;
   logic              err_overflow_reg;

   // expected-value table; never reset, so a loaded program survives reset
   logic [ADDR_W-1:0] exp_pc_mem  [DEPTH];
   logic [CNT_W-1:0]  exp_cyc_mem [DEPTH];

   // error FIFO storage and pointers
   logic [RW-1:0]     fifo_mem [ERR_DEPTH];
   logic [FW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [FW:0]       fifo_cnt_reg;

   // FSM decode outputs
   logic              start_go;
   logic              run_enter;
   logic              close;
   logic              push;
   logic [2:0]        rec_kind;

   logic [IW:0]       idx_p1;
   logic [CNT_W-1:0]  exp_cyc_cur;
   logic [ADDR_W-1:0] exp_pc_nxt;
   logic              cyc_bad, pc_bad, last_instr;
   logic [ADDR_W-1:0] rec_pc;
   logic [RW-1:0]     rec_word;
   logic [RW-1:0]     head_word;
   logic              fifo_full, pop, do_push;

   // index arithmetic: idx+1 is compared against n_entries at full width
   assign idx_p1      = {1'b0, idx_reg} + (IW+1)'(1);
   assign exp_cyc_cur = exp_cyc_mem[idx_reg];
   assign exp_pc_nxt  = exp_pc_mem[idx_p1[IW-1:0]];
   assign cyc_bad     = (cnt_reg != exp_cyc_cur);
   assign pc_bad      = (idx_p1 < n_entries) && (pc != exp_pc_nxt);
   assign last_instr  = (idx_p1 == n_entries);

   // a watchdog record carries the PC of the last fetch, i.e. the stuck instruction
   assign rec_pc   = close ? pc : last_pc_reg;
   assign rec_word = {rec_kind, idx_reg, rec_pc, cnt_reg, exp_cyc_cur};

   assign err_valid = (fifo_cnt_reg != '0);
   assign fifo_full = (fifo_cnt_reg == (FW+1)'(ERR_DEPTH));
   assign pop       = err_valid && err_ready;
   // a push into a full FIFO still succeeds if the head leaves this cycle
   assign do_push   = push && (!fifo_full || pop);

   // head data is forced to zero when empty so outputs are clean after reset
   assign head_word = err_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign {err_kind, err_idx, err_pc, err_meas, err_exp} = head_word;

   assign busy         = (state_reg == S_WAIT_START) || (state_reg == S_RUN);
   assign done         = (state_reg == S_DONE) || (state_reg == S_FAIL_START);
   assign start_fail   = (state_reg == S_FAIL_START);
   assign error_count  = error_count_reg;
   assign err_overflow = err_overflow_reg;
   assign pass         = done && !start_fail && (error_count_reg == 8'd0) && !err_overflow_reg;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // next-state logic and per-cycle decode of run events
   always_comb begin
      state_next = state_reg;
      start_go   = 1'b0;
      run_enter  = 1'b0;
      close      = 1'b0;
      push       = 1'b0;
      rec_kind   = 3'b000;
      case (state_reg)
         S_IDLE, S_DONE, S_FAIL_START: begin
            if (start) begin
               start_go   = 1'b1;
               state_next = S_WAIT_START;
            end
         end
         S_WAIT_START: begin
            if (fetch && (pc == START_ADDR)) begin
               run_enter  = 1'b1;
               state_next = S_RUN;
            end else if (wait_cnt_reg == TW'(START_TIMEOUT - 1)) begin
               state_next = S_FAIL_START;
            end
         end
         S_RUN: begin
            if (fetch) begin
               close = 1'b1;
               if (cyc_bad || pc_bad) begin
                  push     = 1'b1;
                  rec_kind = {1'b0, pc_bad, cyc_bad};
               end
               if (last_instr) state_next = S_DONE;
            end else if (cnt_reg == CNT_W'(WDOG)) begin
               push       = 1'b1;
               rec_kind   = 3'b100;
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // cycle counter, instruction index, start timer and last fetched PC
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg      <= '0;
         idx_reg      <= '0;
         wait_cnt_reg <= '0;
         last_pc_reg  <= '0;
      end else begin
         if (fetch)                cnt_reg <= CNT_W'(1);
         else if (cnt_reg != '1)   cnt_reg <= cnt_reg + CNT_W'(1);
         if (start_go) begin
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
         end else begin
            if (close) idx_reg <= idx_p1[IW-1:0];
            if (state_reg == S_WAIT_START) wait_cnt_reg <= wait_cnt_reg + TW'(1);
         end
         if (run_enter || close) last_pc_reg <= pc;
      end
   end

   // error counter (saturating) and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         error_count_reg  <= '0;
         err_overflow_reg <= 1'b0;
      end else begin
         if (push && (error_count_reg != 8'hFF)) error_count_reg <= error_count_reg + 8'd1;
         if (push && fifo_full && !pop)          err_overflow_reg <= 1'b1;
      end
   end

   // expected-table writes, accepted in any state
   always_ff @(posedge clk) begin
      if (exp_wr_en) begin
         exp_pc_mem[exp_wr_idx]  <= exp_wr_pc;
         exp_cyc_mem[exp_wr_idx] <= exp_wr_cyc;
      end
   end

   // error FIFO data storage
   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr_reg] <= rec_word;
   end

   // error FIFO pointers and occupancy; a new run flushes old records
   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + FW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + FW'(1);
         case ({do_push, pop})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (FW+1)'(1);
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (FW+1)'(1);
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_cycle_check_monitor.sv
// Testbench for cycle_check_monitor: directed cases from the test plan plus
// randomized programs. Expected error records are produced by a program-level
// model (measured cycles = gap between fetches) and queued; a monitor process
// pops and compares them whenever the DUT hands over a record.
module tb_cycle_check_monitor;

   localparam logic [15:0] START_PC = 16'h8000;

   logic        clk = 1'b0;
   logic        reset, start, fetch, exp_wr_en, err_ready;
   logic [4:0]  n_entries;
   logic [15:0] pc, exp_wr_pc;
   logic [3:0]  exp_wr_idx;
   logic [7:0]  exp_wr_cyc;
   logic        busy, done, pass, start_fail, err_overflow, err_valid;
   logic [7:0]  error_count;
   logic [2:0]  err_kind;
   logic [3:0]  err_idx;
   logic [15:0] err_pc;
   logic [7:0]  err_meas, err_exp;

   typedef struct packed {
      logic [2:0]  kind;
      logic [3:0]  idx;
      logic [15:0] pc;
      logic [7:0]  meas;
      logic [7:0]  exp_c;
      logic        chk_pc;
   } rec_t;

   rec_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // bench copy of the table and the program being fed to the DUT
   logic [15:0] tb_pc  [0:15];
   logic [7:0]  tb_cyc [0:15];
   logic [15:0] prog_pc  [0:16];
   int          prog_gap [0:15];

   cycle_check_monitor dut (
      .clk(clk), .reset(reset), .start(start), .n_entries(n_entries),
      .fetch(fetch), .pc(pc), .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx),
      .exp_wr_pc(exp_wr_pc), .exp_wr_cyc(exp_wr_cyc), .busy(busy), .done(done),
      .pass(pass), .start_fail(start_fail), .error_count(error_count),
      .err_overflow(err_overflow), .err_valid(err_valid), .err_ready(err_ready),
      .err_kind(err_kind), .err_idx(err_idx), .err_pc(err_pc),
      .err_meas(err_meas), .err_exp(err_exp)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: every accepted record must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset && err_valid && err_ready) begin
         rec_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL record_unexpected kind=%b idx=%0d pc=%h meas=%0d exp=%0d",
                     err_kind, err_idx, err_pc, err_meas, err_exp);
         end else begin
            e = exp_q.pop_front();
            if (err_kind !== e.kind || err_idx !== e.idx || err_meas !== e.meas ||
                err_exp !== e.exp_c || (e.chk_pc && err_pc !== e.pc)) begin
               errors++;
               $display("FAIL record actual kind=%b idx=%0d pc=%h meas=%0d exp=%0d required kind=%b idx=%0d pc=%h meas=%0d exp=%0d",
                        err_kind, err_idx, err_pc, err_meas, err_exp,
                        e.kind, e.idx, e.pc, e.meas, e.exp_c);
            end else begin
               $display("record ok kind=%b idx=%0d pc=%h meas=%0d exp=%0d",
                        err_kind, err_idx, err_pc, err_meas, err_exp);
            end
         end
      end
   end

   task automatic write_entry(input int i, input logic [15:0] pv, input logic [7:0] cv);
      exp_wr_en  = 1'b1;
      exp_wr_idx = 4'(i);
      exp_wr_pc  = pv;
      exp_wr_cyc = cv;
      tb_pc[i]   = pv;
      tb_cyc[i]  = cv;
      tick;
      exp_wr_en  = 1'b0;
   endtask

   // program-level reference: instruction i takes prog_gap[i] cycles and is
   // followed by a fetch at prog_pc[i+1]
   task automatic model_run(input int n, output int nrec);
      nrec = 0;
      for (int i = 0; i < n; i++) begin
         bit   cb, pb;
         rec_t r;
         cb = (prog_gap[i] != int'(tb_cyc[i]));
         pb = (i + 1 < n) && (prog_pc[i+1] != tb_pc[i+1]);
         if (cb || pb) begin
            r.kind   = {1'b0, pb, cb};
            r.idx    = 4'(i);
            r.pc     = prog_pc[i+1];
            r.meas   = 8'(prog_gap[i]);
            r.exp_c  = tb_cyc[i];
            r.chk_pc = 1'b1;
            exp_q.push_back(r);
            nrec++;
         end
      end
   endtask

   task automatic run_prog(input int n, input bit pre);
      n_entries = 5'(n);
      start = 1'b1;
      tick;
      start = 1'b0;
      @(negedge clk);
      check("busy_rise", 32'(busy), 32'd1);
      if (pre) begin
         fetch = 1'b1;
         pc    = 16'h8001;
         tick;
         fetch = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick;
      fetch = 1'b1;
      pc    = START_PC;
      tick;
      fetch = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat (prog_gap[i] - 1) tick;
         fetch = 1'b1;
         pc    = prog_pc[i+1];
         tick;
         fetch = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic check_end(input string tag, input int nrec);
      $display("run %s: done=%0d pass=%0d error_count=%0d expected_records=%0d",
               tag, done, pass, error_count, nrec);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_pass"}, 32'(pass), 32'(nrec == 0));
      check({tag, "_error_count"}, 32'(error_count), 32'(nrec));
      check({tag, "_overflow"}, 32'(err_overflow), 32'd0);
      check({tag, "_start_fail"}, 32'(start_fail), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick;
      repeat (2) tick;
      @(negedge clk);
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_valid_low"}, 32'(err_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_start_fail"}, 32'(start_fail), 32'd0);
      check({tag, "_error_count"}, 32'(error_count), 32'd0);
      check({tag, "_overflow"}, 32'(err_overflow), 32'd0);
      check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      check({tag, "_err_kind"}, 32'(err_kind), 32'd0);
      check({tag, "_err_idx"}, 32'(err_idx), 32'd0);
      check({tag, "_err_pc"}, 32'(err_pc), 32'd0);
      check({tag, "_err_meas"}, 32'(err_meas), 32'd0);
      check({tag, "_err_exp"}, 32'(err_exp), 32'd0);
   endtask

   task automatic load_directed_table;
      write_entry(0, 16'h8000, 8'd3);
      write_entry(1, 16'h8003, 8'd4);
      write_entry(2, 16'h8007, 8'd2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int nrec;
      reset = 1'b1; start = 1'b0; fetch = 1'b0; pc = '0; n_entries = 5'd3;
      exp_wr_en = 1'b0; exp_wr_idx = '0; exp_wr_pc = '0; exp_wr_cyc = '0;
      err_ready = 1'b0;
      repeat (3) tick;
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      err_ready = 1'b1;
      load_directed_table;

      // clean program
      prog_pc[0] = 16'h8000; prog_pc[1] = 16'h8003; prog_pc[2] = 16'h8007; prog_pc[3] = 16'h1234;
      prog_gap[0] = 3; prog_gap[1] = 4; prog_gap[2] = 2;
      model_run(3, nrec);
      run_prog(3, 1'b0);
      check_end("clean", nrec);
      drain("clean");

      // cycle mismatch on instruction 0
      prog_gap[0] = 4;
      model_run(3, nrec);
      run_prog(3, 1'b1);
      check_end("cyc_bad", nrec);
      drain("cyc_bad");

      // PC mismatch on the fetch that closes instruction 0
      prog_gap[0] = 3; prog_pc[1] = 16'h8004;
      model_run(3, nrec);
      run_prog(3, 1'b0);
      check_end("pc_bad", nrec);
      drain("pc_bad");

      // start timeout: only a non-START_ADDR fetch arrives
      n_entries = 5'd3;
      start = 1'b1; tick; start = 1'b0;
      fetch = 1'b1; pc = 16'h8001; tick; fetch = 1'b0;
      repeat (58) tick;
      @(negedge clk);
      check("timeout_not_yet_done", 32'(done), 32'd0);
      check("timeout_still_busy", 32'(busy), 32'd1);
      repeat (10) tick;
      @(negedge clk);
      $display("run timeout: done=%0d start_fail=%0d pass=%0d", done, start_fail, pass);
      check("timeout_done", 32'(done), 32'd1);
      check("timeout_start_fail", 32'(start_fail), 32'd1);
      check("timeout_pass", 32'(pass), 32'd0);
      check("timeout_error_count", 32'(error_count), 32'd0);
      check("timeout_err_valid", 32'(err_valid), 32'd0);

      // watchdog: first fetch, then silence
      begin
         rec_t r;
         r.kind = 3'b100; r.idx = 4'd0; r.pc = '0; r.meas = 8'd32;
         r.exp_c = tb_cyc[0]; r.chk_pc = 1'b0;
         exp_q.push_back(r);
      end
      start = 1'b1; tick; start = 1'b0;
      tick;
      fetch = 1'b1; pc = START_PC; tick; fetch = 1'b0;
      repeat (20) tick;
      @(negedge clk);
      check("wdog_not_yet_done", 32'(done), 32'd0);
      repeat (15) tick;
      @(negedge clk);
      $display("run watchdog: done=%0d pass=%0d error_count=%0d", done, pass, error_count);
      check("wdog_done", 32'(done), 32'd1);
      check("wdog_pass", 32'(pass), 32'd0);
      check("wdog_error_count", 32'(error_count), 32'd1);
      drain("wdog");

      // overflow: six bad instructions, consumer stalled, FIFO holds four
      err_ready = 1'b0;
      for (int i = 0; i < 6; i++) write_entry(i, 16'h8000 + 16'(2 * i), 8'd5);
      for (int i = 0; i < 6; i++) begin
         prog_pc[i] = tb_pc[i];
         prog_gap[i] = 2;
      end
      prog_pc[6] = 16'h4444;
      model_run(6, nrec);
      while (exp_q.size() > 4) void'(exp_q.pop_back());
      run_prog(6, 1'b0);
      $display("run overflow: done=%0d overflow=%0d error_count=%0d", done, err_overflow, error_count);
      check("ovf_done", 32'(done), 32'd1);
      check("ovf_flag", 32'(err_overflow), 32'd1);
      check("ovf_error_count", 32'(error_count), 32'(nrec));
      check("ovf_err_valid", 32'(err_valid), 32'd1);
      check("ovf_head_idx", 32'(err_idx), 32'd0);
      check("ovf_pass", 32'(pass), 32'd0);
      err_ready = 1'b1;
      drain("ovf");
      check("ovf_pass_after_drain", 32'(pass), 32'd0);

      // reset in the middle of a run with a record held
      err_ready = 1'b0;
      n_entries = 5'd6;
      start = 1'b1; tick; start = 1'b0;
      fetch = 1'b1; pc = START_PC; tick; fetch = 1'b0;
      fetch = 1'b1; pc = tb_pc[1]; tick; fetch = 1'b0;
      @(negedge clk);
      check("midrun_busy", 32'(busy), 32'd1);
      check("midrun_err_valid", 32'(err_valid), 32'd1);
      reset = 1'b1; tick;
      @(negedge clk);
      check_all_zero("midrun_reset");
      reset = 1'b0;
      err_ready = 1'b1;
      tick;

      // randomized programs
      for (int run = 0; run < 25; run++) begin
         int n;
         n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++)
            write_entry(i, 16'($urandom), 8'($urandom_range(1, 12)));
         prog_pc[0] = START_PC;
         for (int i = 1; i < n; i++)
            prog_pc[i] = ($urandom_range(0, 4) == 0) ? (tb_pc[i] ^ 16'h0010) : tb_pc[i];
         prog_pc[n] = 16'($urandom);
         for (int i = 0; i < n; i++)
            prog_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'(tb_cyc[i]);
         model_run(n, nrec);
         run_prog(n, 1'($urandom_range(0, 1)));
         check_end($sformatf("rand%0d", run), nrec);
         drain($sformatf("rand%0d", run));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
